// File: rtl/spread_16p.sv
// Frame generator: spreads a 12-bit two's-complement value over 16 sign-magnitude
// samples paced by a self-generated sample clock (syn_out).
module spread_16p #(
    parameter int HALF = 10
) (
    input  logic        clk,
    input  logic        res,
    input  logic [11:0] data_in,
    input  logic        syn_in,
    output logic [7:0]  data_out,
    output logic        syn_out,
    output logic        frm,
    output logic        ovf
);

    localparam int HCW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic signed [11:0] SAT_P = 12'sd2032;
    localparam logic signed [11:0] SAT_N = -12'sd2032;

    logic [HCW-1:0]     hc;
    logic [3:0]         k;
    logic [11:0]        pv;
    logic               pf;
    logic signed [7:0]  q;
    logic [3:0]         r;

    logic signed [11:0] din_s;
    logic signed [11:0] sat_val;
    logic               hc_wrap;
    logic               fall;
    logic               bnd;
    logic [3:0]         k_nxt;
    logic signed [7:0]  nq;
    logic [3:0]         nr;

    // sample idx = q + (idx < r); result always within +/-127, so -s fits in 7 bits
    function automatic logic [7:0] enc(input logic signed [7:0] qq,
                                       input logic [3:0] rr,
                                       input logic [3:0] idx);
        logic signed [7:0] s;
        logic signed [7:0] m;
        s = qq + ((idx < rr) ? 8'sd1 : 8'sd0);
        m = -s;
        if (s < 0)
            return {1'b1, m[6:0]};
        return {1'b0, s[6:0]};
    endfunction

    assign din_s = data_in;

    always_comb begin
        sat_val = din_s;
        if (din_s > SAT_P)
            sat_val = SAT_P;
        else if (din_s < SAT_N)
            sat_val = SAT_N;
    end

    assign hc_wrap = (hc == HCW'(HALF - 1));
    assign fall    = hc_wrap && syn_out;
    assign bnd     = fall && (k == 4'd15);
    assign k_nxt   = k + 4'd1;
    // pv is saturated to +/-2032, so pv[11:4] is the floor quotient without loss
    assign nq      = pf ? signed'(pv[11:4]) : 8'sd0;
    assign nr      = pf ? pv[3:0] : 4'd0;

    always_ff @(posedge clk) begin
        if (!res) begin
            hc       <= '0;
            k        <= 4'd0;
            q        <= 8'sd0;
            r        <= 4'd0;
            pv       <= 12'd0;
            pf       <= 1'b0;
            data_out <= 8'h00;
            syn_out  <= 1'b0;
            frm      <= 1'b1;
            ovf      <= 1'b0;
        end else begin
            hc <= hc_wrap ? '0 : hc + 1'b1;
            if (hc_wrap)
                syn_out <= ~syn_out;

            if (fall) begin
                k   <= k_nxt;
                frm <= (k_nxt == 4'd0);
                if (bnd) begin
                    q        <= nq;
                    r        <= nr;
                    data_out <= enc(nq, nr, 4'd0);
                end else begin
                    data_out <= enc(q, r, k_nxt);
                end
            end

            // a write landing on the boundary edge refills pv just as the old value loads
            ovf <= syn_in && pf && !bnd;
            if (syn_in) begin
                pv <= sat_val;
                pf <= 1'b1;
            end else if (bnd) begin
                pf <= 1'b0;
            end
        end
    end

endmodule
